// File: rtl/data_sram_responder_pkg.sv
// Shared request-entry layout, head FSM states and small helpers for the data SRAM responder.
// Combinational helpers only; no timing or flow-control semantics live here.
package data_sram_responder_pkg;

  localparam int IDX_W = 30;
  localparam int LAT_W = 4;

  typedef struct packed {
    logic             wr;
    logic [3:0]       wstrb;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
  } req_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2
  } resp_state_t;

  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order request queue with a per-entry latency down-counter; push/pop each take one edge.
// No internal backpressure: the owner must not push when full nor pop when empty.
module resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  req_entry_t                 push_entry,
  input  logic                       pop,
  output logic [$clog2(QDEPTH):0]    count,
  output req_entry_t                 head_entry,
  output logic [LAT_W-1:0]           head_cnt,
  output logic [LAT_W-1:0]           next_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

  req_entry_t         entries [QDEPTH];
  logic [LAT_W-1:0]   cnt_q   [QDEPTH];
  logic [PTR_W-1:0]   head_q, tail_q, head_nxt;
  logic [PTR_W:0]     count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) cnt_q[i] <= '0;
    end else begin
      // Counters saturate at zero, so entries queued behind the head simply wait there.
      for (int i = 0; i < QDEPTH; i++) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
      if (push) begin
        cnt_q[tail_q] <= CNT_INIT;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_nxt;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[tail_q] <= push_entry;
  end

  assign head_nxt   = head_q + 1'b1;
  assign count      = count_q;
  assign head_entry = entries[head_q];
  assign head_cnt   = cnt_q[head_q];
  assign next_cnt   = cnt_q[head_nxt];

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM-like responder: in-order completion LATENCY cycles after acceptance, one per cycle.
// addr_ok drops when the queue is full or stall_in is high; a retiring slot frees only next cycle.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int AW_WORDS = 16,
  parameter int LATENCY  = 2,
  parameter int QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        stall_in,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(QDEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

  logic [31:0]         mem [0:(1<<AW_WORDS)-1];
  logic [CNT_W-1:0]    count;
  req_entry_t          push_entry, head;
  logic [LAT_W-1:0]    head_cnt, next_cnt, cnt_nxt;
  logic                push, pop, has_nxt;
  resp_state_t         state_q, state_d;
  logic [AW_WORDS-1:0] head_idx;
  logic [31:0]         rd_word, rdata_q;
  logic                unused_ok;

  assign data_sram_addr_ok = resetn && !stall_in && (count < FULL);
  assign push              = data_sram_req && data_sram_addr_ok;
  assign pop               = (state_q == ST_RESP);
  assign data_sram_data_ok = pop;

  assign push_entry = '{wr: data_sram_wr, wstrb: data_sram_wstrb,
                        idx: data_sram_addr[31:2], wdata: data_sram_wdata};

  resp_fifo #(.QDEPTH(QDEPTH), .LATENCY(LATENCY)) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head_entry (head),
    .head_cnt   (head_cnt),
    .next_cnt   (next_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // Predict next cycle's head counter: surviving head, the entry behind a popped head, or a fresh push.
  always_comb begin
    state_d = ST_EMPTY;
    has_nxt = 1'b0;
    cnt_nxt = '0;
    if (count != '0 && !pop) begin
      has_nxt = 1'b1;
      cnt_nxt = dec_sat(head_cnt);
    end else if (pop && count > CNT_W'(1)) begin
      has_nxt = 1'b1;
      cnt_nxt = dec_sat(next_cnt);
    end else if (push) begin
      has_nxt = 1'b1;
      cnt_nxt = CNT_INIT;
    end
    if (has_nxt) state_d = (cnt_nxt == '0) ? ST_RESP : ST_WAIT;
  end

  assign head_idx        = head.idx[AW_WORDS-1:0];
  assign rd_word         = mem[head_idx];
  assign data_sram_rdata = (pop && !head.wr) ? rd_word : rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= data_sram_rdata;
  end

  // Array is deliberately outside reset so contents survive a resetn pulse.
  always_ff @(posedge clk) begin
    if (pop && head.wr) mem[head_idx] <= merge_bytes(rd_word, head.wdata, head.wstrb);
  end

  assign unused_ok = ^{data_sram_addr[1:0], head.idx[IDX_W-1:AW_WORDS]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: lane 0 runs LATENCY=2, lane 1 runs LATENCY=15; both share clock and reset.
module tb_data_sram_responder;

  typedef struct {
    int          d;
    bit          wr;
    logic [3:0]  strb;
    int          key;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetn;
  logic [1:0]  req, wr, stall;
  logic [3:0]  wstrb [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        aok0, aok1, dok0, dok1;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int failures = 0;

  data_sram_responder #(.AW_WORDS(16), .LATENCY(2), .QDEPTH(4)) u_dut0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .stall_in(stall[0]), .data_sram_addr_ok(aok0), .data_sram_data_ok(dok0),
    .data_sram_rdata(rd0));

  data_sram_responder #(.AW_WORDS(16), .LATENCY(15), .QDEPTH(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .stall_in(stall[1]), .data_sram_addr_ok(aok1), .data_sram_data_ok(dok1),
    .data_sram_rdata(rd1));

  ent_t        sb0 [$];
  ent_t        sb1 [$];
  logic [31:0] mem_m [int];
  int          last_d [2];
  int          acc_cyc [2];
  int          dok_cyc [2];
  int          n_dok [2];
  logic [31:0] exp_rd [2];
  logic [31:0] last_load [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int lane);
    return (lane == 0) ? 2 : 15;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic int sb_size(input int lane);
    return (lane == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_front(input int lane, output ent_t e);
    if (lane == 0) e = sb0[0];
    else           e = sb1[0];
  endtask

  task automatic sb_pop(input int lane);
    if (lane == 0) void'(sb0.pop_front());
    else           void'(sb1.pop_front());
  endtask

  task automatic sb_push(input int lane, input ent_t e);
    if (lane == 0) sb0.push_back(e);
    else           sb1.push_back(e);
  endtask

  task automatic sb_clear(input int lane);
    if (lane == 0) sb0.delete();
    else           sb1.delete();
  endtask

  task automatic mon(input int lane);
    logic        aok, dok, exp_aok, exp_dok;
    logic [31:0] rd, base;
    ent_t        e;
    aok = (lane == 0) ? aok0 : aok1;
    dok = (lane == 0) ? dok0 : dok1;
    rd  = (lane == 0) ? rd0  : rd1;
    if (!resetn) begin
      check_eq($sformatf("rst_addr_ok%0d", lane), aok, 1'b0);
      check_eq($sformatf("rst_data_ok%0d", lane), dok, 1'b0);
      check_eq($sformatf("rst_rdata%0d", lane), rd, 32'h0);
      sb_clear(lane);
      last_d[lane] = 0;
      exp_rd[lane] = 32'h0;
    end else begin
      exp_aok = !stall[lane] && (sb_size(lane) < 4);
      exp_dok = 1'b0;
      if (sb_size(lane) > 0) begin
        sb_front(lane, e);
        exp_dok = (e.d == cyc);
      end
      check_eq($sformatf("addr_ok%0d", lane), aok, exp_aok);
      check_eq($sformatf("data_ok%0d", lane), dok, exp_dok);
      if (exp_dok) begin
        sb_pop(lane);
        n_dok[lane]++;
        if (e.wr) begin
          base = mem_m.exists(e.key) ? mem_m[e.key] : 32'h0;
          mem_m[e.key] = model_merge(base, e.data, e.strb);
        end else begin
          exp_rd[lane]    = mem_m[e.key];
          last_load[lane] = rd;
          dok_cyc[lane]   = cyc;
        end
      end
      check_eq($sformatf("rdata%0d", lane), rd, exp_rd[lane]);
      if (req[lane] && exp_aok) begin
        e.d    = imax(cyc + lat(lane), last_d[lane] + 1);
        e.wr   = wr[lane];
        e.strb = wstrb[lane];
        e.key  = lane * 65536 + int'(addr[lane][17:2]);
        e.data = wdata[lane];
        sb_push(lane, e);
        last_d[lane]  = e.d;
        acc_cyc[lane] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input int lane, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    logic ok;
    int   n;
    req[lane] = 1'b1; wr[lane] = w; wstrb[lane] = s; addr[lane] = a; wdata[lane] = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = (lane == 0) ? aok0 : aok1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check_eq("issue_timeout", 32'd0, 32'd1);
    req[lane] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc1, n_before;
    resetn = 1'b1; req = '0; wr = '0; stall = '0;
    for (int i = 0; i < 2; i++) begin
      wstrb[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    #1 resetn = 1'b0;

    // Reset with req held high: nothing accepted, outputs quiet.
    req = 2'b11;
    idle(3);
    req = 2'b00;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("t1_rdata", rd0, 32'h0);
    check_eq("t1_addr_ok", aok0, 1'b1);
    idle(1);

    // Lane 0 preloads.
    issue(0, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    issue(0, 1, 4'hF, 32'h140, 32'hAABBCCDD);
    for (int i = 0; i < 6; i++) issue(0, 1, 4'hF, 32'h180 + 4*i, 32'hC0DE0000 + i);
    idle(4);

    // Single load latency.
    issue(0, 0, 4'h0, 32'h100, 32'h0);
    idle(4);
    check_eq("t2_latency", dok_cyc[0] - acc_cyc[0], 32'd2);
    check_eq("t2_rdata", last_load[0], 32'hDEADBEEF);

    // Partial store then back-to-back load of the same word.
    issue(0, 1, 4'b0101, 32'h140, 32'h11223344);
    issue(0, 0, 4'h0, 32'h140, 32'h0);
    idle(4);
    check_eq("t3_rdata", last_load[0], 32'hAA22CC44);

    // Streaming loads with a 3-cycle stall in the middle.
    n_before = n_dok[0];
    fork
      for (int i = 0; i < 6; i++) issue(0, 0, 4'h0, 32'h180 + 4*i, 32'h0);
      begin
        idle(2);
        stall[0] = 1'b1;
        idle(3);
        stall[0] = 1'b0;
      end
    join
    idle(6);
    check_eq("t5_count", n_dok[0] - n_before, 32'd6);
    check_eq("t5_last", last_load[0], 32'hC0DE0005);

    // Lane 1 (LATENCY=15): preload, then fill the queue.
    issue(1, 1, 4'hF, 32'h80, 32'h55667788);
    idle(17);
    issue(1, 1, 4'hF, 32'h40, 32'h10000000);
    acc1 = acc_cyc[1];
    for (int i = 1; i < 4; i++) issue(1, 1, 4'hF, 32'h40 + 4*i, 32'h10000000 + i);
    fork
      issue(1, 0, 4'h0, 32'h40, 32'h0);
      begin
        @(negedge clk);
        check_eq("t4_full_addr_ok", aok1, 1'b0);
      end
    join
    check_eq("t4_accept_gap", acc_cyc[1] - acc1, 32'd16);
    idle(20);
    check_eq("t4_order", last_load[1], 32'h10000000);

    // Reset with three outstanding requests, one of them a store.
    n_before = n_dok[1];
    issue(1, 1, 4'hF, 32'h80, 32'h99999999);
    issue(1, 0, 4'h0, 32'h44, 32'h0);
    issue(1, 0, 4'h0, 32'h48, 32'h0);
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(20);
    check_eq("t6_no_data_ok", n_dok[1] - n_before, 32'd0);
    issue(1, 0, 4'h0, 32'h80, 32'h0);
    idle(17);
    check_eq("t6_latency", dok_cyc[1] - acc_cyc[1], 32'd15);
    check_eq("t6_word_kept", last_load[1], 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
